// File: rtl/min_code_enumerator_pkg.sv
// Shared types and helpers for the code enumerator: the f classifier, scan bounds, FSM states.
// MINENUM_FULL_RANGE_EN (top) selects IDX_MAX_FULL instead of IDX_MAX_BCD.
package minimization_pkg;

  localparam logic [3:0] IDX_MAX_BCD  = 4'd9;
  localparam logic [3:0] IDX_MAX_FULL = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [1:0] min_f(input logic [3:0] d);
    logic [1:0] f;
    case (d)
      4'd0, 4'd3, 4'd5, 4'd8: f = 2'd3;
      4'd1, 4'd6, 4'd14:      f = 2'd2;
      4'd2, 4'd7:             f = 2'd1;
      default:                f = 2'd0;
    endcase
    return f;
  endfunction

  // True when some digit strictly above idx, up to max, classifies to code.
  function automatic logic min_any_above(input logic [3:0] idx,
                                         input logic [1:0] code,
                                         input logic [3:0] max);
    logic       found;
    logic [3:0] d;
    found = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      d = 4'(i);
      if ((d > idx) && (d <= max) && (min_f(d) == code))
        found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/min_code_enumerator_if.sv
// Request / digit-stream / completion bundle for min_code_enumerator.
interface min_code_enumerator_if #(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned CODE_W  = 2
);
  logic               req_valid;
  logic               req_ready;
  logic [CODE_W-1:0]  req_code;
  logic               out_valid;
  logic               out_ready;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_last;
  logic               done;
  logic [DIGIT_W-1:0] match_count;

  modport slave (
    input  req_valid, req_code, out_ready,
    output req_ready, out_valid, out_digit, out_last, done, match_count
  );

  modport master (
    output req_valid, req_code, out_ready,
    input  req_ready, out_valid, out_digit, out_last, done, match_count
  );
endinterface

// File: rtl/min_code_enumerator_lut.sv
// Combinational wrapper around the f classifier used to test each scanned index.
module min_code_lut
  import minimization_pkg::*;
(
  input  logic [3:0] digit,
  output logic [1:0] code
);
  always_comb begin
    code = min_f(digit);
  end
endmodule

// File: rtl/min_code_enumerator.sv
// Enumerates, in ascending order, every digit whose class equals the requested code.
// Define MINENUM_FULL_RANGE_EN to scan 0..15 instead of the BCD range 0..9.
module min_code_enumerator
  import minimization_pkg::*;
#(
  parameter int unsigned DIGIT_W = 4,
  parameter int unsigned CODE_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  min_code_enumerator_if.slave  bus
);

`ifdef MINENUM_FULL_RANGE_EN
  localparam logic [DIGIT_W-1:0] IDX_MAX = IDX_MAX_FULL;
`else
  localparam logic [DIGIT_W-1:0] IDX_MAX = IDX_MAX_BCD;
`endif

  state_t             state, state_d;
  logic [DIGIT_W-1:0] idx, idx_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [DIGIT_W-1:0] count_q, count_d;
  logic [CODE_W-1:0]  f_idx;
  logic               match;
  logic               advance;

  min_code_lut u_lut (
    .digit (idx),
    .code  (f_idx)
  );

  assign match = (f_idx == code_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      code_q  <= '0;
      count_q <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  // A non-matching index is skipped immediately; a matching one waits for the consumer.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    code_d  = code_q;
    count_d = count_q;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          code_d  = bus.req_code;
          idx_d   = '0;
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        advance = !match || bus.out_ready;
        if (match && bus.out_ready)
          count_d = count_q + DIGIT_W'(1);
        if (advance) begin
          if (idx == IDX_MAX)
            state_d = DONE;
          else
            idx_d = idx + DIGIT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.out_valid   = (state == SCAN) && match;
  assign bus.out_digit   = bus.out_valid ? idx : '0;
  assign bus.out_last    = bus.out_valid && !min_any_above(idx, code_q, IDX_MAX);
  assign bus.done        = (state == DONE);
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_min_code_enumerator.sv
// Scoreboard bench for min_code_enumerator; expectations follow MINENUM_FULL_RANGE_EN.
module tb_min_code_enumerator;

`ifdef MINENUM_FULL_RANGE_EN
  localparam bit FULL = 1'b1;
  localparam int SCAN_CYC = 16;
`else
  localparam bit FULL = 1'b0;
  localparam int SCAN_CYC = 10;
`endif

  typedef struct { logic [3:0] d; logic last; } beat_t;
  typedef struct { logic [3:0] cnt; int delta; } done_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  beat_t beat_q[$];
  done_t done_q[$];

  min_code_enumerator_if #(.DIGIT_W(4), .CODE_W(2)) bus ();

  min_code_enumerator #(.DIGIT_W(4), .CODE_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input logic [3:0] d, input logic last);
    beat_t b;
    b.d = d;
    b.last = last;
    beat_q.push_back(b);
  endtask

  task automatic push_done(input logic [3:0] cnt, input int delta);
    done_t e;
    e.cnt = cnt;
    e.delta = delta;
    done_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from input changes and state updates.
  logic       stall_prev = 1'b0;
  logic [3:0] prev_digit;
  logic       prev_last;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (stall_prev) begin
          chk("hold_digit", bus.out_digit, prev_digit);
          chk("hold_last", bus.out_last, prev_last);
        end
        if (bus.out_ready) begin
          if (beat_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got digit %0d expected no beat", bus.out_digit);
          end else begin
            beat_t b;
            b = beat_q.pop_front();
            chk("beat_digit", bus.out_digit, b.d);
            chk("beat_last", bus.out_last, b.last);
          end
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          prev_digit = bus.out_digit;
          prev_last  = bus.out_last;
        end
      end else begin
        if (stall_prev) chk("valid_dropped", 0, 1);
        stall_prev = 1'b0;
        chk("last_without_valid", bus.out_last, 0);
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done pulse expected none (cycle %0d)", cyc);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_count", bus.match_count, e.cnt);
          chk("done_latency", cyc - accept_cyc, e.delta);
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [1:0] code);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_code  = code;
    for (int i = 0; i < 60; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    accept_cyc = cyc + 1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_code  = 2'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_match_count", bus.match_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: code 3, consumer always ready
    push_beat(4'd0, 1'b0); push_beat(4'd3, 1'b0);
    push_beat(4'd5, 1'b0); push_beat(4'd8, 1'b1);
    push_done(4'd4, SCAN_CYC);
    send(2'd3);
    wait_done();
    @(posedge clk); #1;
    chk("t1_count_hold", bus.match_count, 4);
    chk("t1_idle_ready", bus.req_ready, 1);

    // Test 2: code 2, first beat stalled for three cycles
    bus.out_ready = 1'b0;
    push_beat(4'd1, 1'b0);
    push_beat(4'd6, FULL ? 1'b0 : 1'b1);
    if (FULL) push_beat(4'd14, 1'b1);
    push_done(FULL ? 4'd3 : 4'd2, SCAN_CYC + 3);
    send(2'd2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t2_first_beat_seen", seen, 1);
    chk("t2_first_beat_cycle", cyc - accept_cyc, 1);
    repeat (3) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    wait_done();
    @(posedge clk); #1;
    chk("t2_count_hold", bus.match_count, FULL ? 3 : 2);

    // Test 3: request during scan is refused and does not disturb the scan
    push_beat(4'd4, 1'b0);
    if (FULL) begin
      push_beat(4'd9, 1'b0);  push_beat(4'd10, 1'b0); push_beat(4'd11, 1'b0);
      push_beat(4'd12, 1'b0); push_beat(4'd13, 1'b0); push_beat(4'd15, 1'b1);
    end else begin
      push_beat(4'd9, 1'b1);
    end
    push_done(FULL ? 4'd7 : 4'd2, SCAN_CYC);
    send(2'd0);
    bus.req_valid = 1'b1;
    bus.req_code  = 2'd1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_busy_not_ready", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    wait_done();
    @(posedge clk); #1;
    push_beat(4'd2, 1'b0); push_beat(4'd7, 1'b1);
    push_done(4'd2, SCAN_CYC);
    send(2'd1);
    wait_done();

    // Test 6: back-to-back request in the cycle after done
    @(posedge clk); #1;
    chk("t6_ready_after_done", bus.req_ready, 1);
    chk("t6_count_before", bus.match_count, 2);
    push_beat(4'd0, 1'b0); push_beat(4'd3, 1'b0);
    push_beat(4'd5, 1'b0); push_beat(4'd8, 1'b1);
    push_done(4'd4, SCAN_CYC);
    send(2'd3);
    chk("t6_accept_latency", cyc - accept_cyc, 0);
    chk("t6_count_cleared", bus.match_count, 0);
    wait_done();
    @(posedge clk); #1;

    // Test 4: reset in cycle T+5 of a code-3 scan aborts without a done pulse
    push_beat(4'd0, 1'b0); push_beat(4'd3, 1'b0);
    send(2'd3);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t4_req_ready", bus.req_ready, 1);
    chk("t4_out_valid", bus.out_valid, 0);
    chk("t4_done", bus.done, 0);
    chk("t4_match_count", bus.match_count, 0);
    rst_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("t4_idle_ready", bus.req_ready, 1);

    chk("beats_outstanding", beat_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
